// File: rtl/ddls_pkg.sv
// Shared definitions for the error-capture block: parameter defaults and the
// capture FSM state encoding.
package ddls_pkg;

    localparam int BUFFERWIDTH_DEF = 256;
    localparam int DEPTH_DEF       = 4;
    localparam int CNTW_DEF        = 16;

    // Capture session state; encoding is fixed so checkers can decode it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/ddls_err_fifo.sv
// First-word-fall-through capture FIFO with synchronous flush.
// Handshake: an entry is written when push=1 and the FIFO can take it; an
// entry is removed when pop=1 and empty=0; pop_data always shows the head
// entry and reads zero while empty.
module ddls_err_fifo
    import ddls_pkg::*;
#(
    parameter int WIDTH = CNTW_DEF + BUFFERWIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Qualify requests: a pop needs data; a push needs room unless a pop frees
    // a slot in the same cycle; a push paired with a pop on an empty FIFO
    // passes straight through and leaves it empty. Flush overrides both.
    always_comb begin
        do_pop  = pop && !empty && !flush;
        do_push = push && !flush && (!full || do_pop) && !(empty && pop);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!resetb || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only meaningful behind the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ddls_err_capture.sv
// Error capture: records compare-stage mismatches with a session timestamp
// into a FWFT FIFO, counts them, and optionally halts on the first one.
// Readout handshake: an entry is consumed on a clk edge where rd_valid=1 and
// rd_ready=1; rd_ready is ignored while rd_valid=0, and rd_data/rd_tstamp hold
// while rd_valid=1 and rd_ready=0.
module ddls_err_capture
    import ddls_pkg::*;
#(
    parameter int BUFFERWIDTH = BUFFERWIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int CNTW        = CNTW_DEF
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   arm,
    input  logic                   clear,
    input  logic                   stop_on_err,
    input  logic                   result_flag,
    input  logic [BUFFERWIDTH-1:0] result,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [BUFFERWIDTH-1:0] rd_data,
    output logic [CNTW-1:0]        rd_tstamp,
    output logic [CNTW-1:0]        err_count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   halted
);

    localparam int FW = CNTW + BUFFERWIDTH;

    state_t          state;
    state_t          state_next;
    logic            arm_go;
    logic            capture;
    logic            pop;
    logic [CNTW-1:0] tstamp;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FW-1:0]   fifo_out;

    assign capture  = (state == ARMED) && result_flag;
    assign rd_valid = !fifo_empty;
    assign pop      = rd_valid && rd_ready;

    // Next-state decode; clear wins over arm, arm is ignored while ARMED.
    always_comb begin
        state_next = state;
        arm_go     = 1'b0;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        arm_go     = 1'b1;
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (result_flag && stop_on_err) state_next = HALTED;
                end
                HALTED: begin
                    if (arm) begin
                        arm_go     = 1'b1;
                        state_next = ARMED;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register with registered status decodes.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state  <= IDLE;
            busy   <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            busy   <= (state_next == ARMED);
            halted <= (state_next == HALTED);
        end
    end

    // Session timestamp, saturating error counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (!resetb || arm_go) begin
            tstamp    <= '0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (state == ARMED) tstamp <= tstamp + CNTW'(1);
            if (capture && (err_count != '1)) err_count <= err_count + CNTW'(1);
            if (capture && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    ddls_err_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetb    (resetb),
        .flush     (arm_go),
        .push      (capture),
        .push_data ({tstamp, result}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_tstamp = fifo_out[FW-1 -: CNTW];
    assign rd_data   = fifo_out[BUFFERWIDTH-1:0];

endmodule

// File: tb/tb_ddls_err_capture.sv
// Directed bench for ddls_err_capture with immediate-assertion checks.
module tb_ddls_err_capture;

    localparam int BW   = 256;
    localparam int CNTW = 16;

    logic          clk = 1'b0;
    logic          resetb;
    logic          arm;
    logic          clear;
    logic          stop_on_err;
    logic          result_flag;
    logic [BW-1:0] result;
    logic          rd_valid;
    logic          rd_ready;
    logic [BW-1:0] rd_data;
    logic [CNTW-1:0] rd_tstamp;
    logic [CNTW-1:0] err_count;
    logic          overflow;
    logic          busy;
    logic          halted;

    int total = 0;
    int bad   = 0;

    ddls_err_capture #(
        .BUFFERWIDTH (BW),
        .DEPTH       (4),
        .CNTW        (CNTW)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .arm         (arm),
        .clear       (clear),
        .stop_on_err (stop_on_err),
        .result_flag (result_flag),
        .result      (result),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_tstamp   (rd_tstamp),
        .err_count   (err_count),
        .overflow    (overflow),
        .busy        (busy),
        .halted      (halted)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Return to IDLE, then arm; leaves the bench in ARMED cycle 0.
    task automatic start_session();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        arm   = 1'b1;
        tick();
        arm   = 1'b0;
    endtask

    initial begin
        resetb = 1'b0; arm = 1'b0; clear = 1'b0; stop_on_err = 1'b0;
        result_flag = 1'b0; result = '0; rd_ready = 1'b0;
        tick();
        resetb = 1'b1;

        // Reset state
        chk("rst_valid", BW'(rd_valid), BW'(0));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_halted", BW'(halted), BW'(0));
        chk("rst_err", BW'(err_count), BW'(0));
        chk("rst_ovf", BW'(overflow), BW'(0));
        chk("rst_data", rd_data, BW'(0));
        chk("rst_ts", BW'(rd_tstamp), BW'(0));

        // Two flags at cycles 3 and 7; arm pulse in cycle 5 must not restart
        start_session();
        chk("t1_busy", BW'(busy), BW'(1));
        repeat (3) tick();
        result_flag = 1'b1; result = BW'(1);
        tick();
        result_flag = 1'b0;
        chk("t1_valid", BW'(rd_valid), BW'(1));
        chk("t1_err1", BW'(err_count), BW'(1));
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        result_flag = 1'b1; result = BW'(2);
        tick();
        result_flag = 1'b0;
        chk("t1_err2", BW'(err_count), BW'(2));
        rd_ready = 1'b1;
        chk("t1_h0_ts", BW'(rd_tstamp), BW'(3));
        chk("t1_h0_d", rd_data, BW'(1));
        tick();
        chk("t1_h1_ts", BW'(rd_tstamp), BW'(7));
        chk("t1_h1_d", rd_data, BW'(2));
        tick();
        rd_ready = 1'b0;
        chk("t1_empty", BW'(rd_valid), BW'(0));

        // Six consecutive flags with no readout: four stored, two dropped
        start_session();
        result_flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            result = BW'(32'h10 + i);
            tick();
            chk("t2_hold_d", rd_data, BW'(32'h10));
            chk("t2_hold_ts", BW'(rd_tstamp), BW'(0));
        end
        result_flag = 1'b0;
        chk("t2_err", BW'(err_count), BW'(6));
        chk("t2_ovf", BW'(overflow), BW'(1));
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop_valid", BW'(rd_valid), BW'(1));
            chk("t2_pop_d", rd_data, BW'(32'h10 + i));
            chk("t2_pop_ts", BW'(rd_tstamp), BW'(i));
            tick();
        end
        rd_ready = 1'b0;
        chk("t2_empty", BW'(rd_valid), BW'(0));

        // Fill, then push and pop together on a full FIFO
        start_session();
        chk("t3_ovf_clr", BW'(overflow), BW'(0));
        result_flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            result = BW'(32'h20 + i);
            tick();
        end
        result = BW'(32'h24);
        rd_ready = 1'b1;
        tick();
        result_flag = 1'b0;
        chk("t3_ovf", BW'(overflow), BW'(0));
        chk("t3_err", BW'(err_count), BW'(5));
        for (int i = 0; i < 4; i++) begin
            chk("t3_pop_valid", BW'(rd_valid), BW'(1));
            chk("t3_pop_d", rd_data, BW'(32'h21 + i));
            chk("t3_pop_ts", BW'(rd_tstamp), BW'(1 + i));
            tick();
        end
        rd_ready = 1'b0;
        chk("t3_empty", BW'(rd_valid), BW'(0));

        // Stop on error at cycle 5; later flags ignored, timestamp frozen at 6
        stop_on_err = 1'b1;
        start_session();
        repeat (5) tick();
        result_flag = 1'b1; result = BW'(32'h55);
        tick();
        chk("t4_halted", BW'(halted), BW'(1));
        chk("t4_busy", BW'(busy), BW'(0));
        chk("t4_err1", BW'(err_count), BW'(1));
        chk("t4_ts", BW'(rd_tstamp), BW'(5));
        chk("t4_d", rd_data, BW'(32'h55));
        repeat (3) tick();
        result_flag = 1'b0;
        chk("t4_err_hold", BW'(err_count), BW'(1));
        chk("t4_ts_frozen", BW'(dut.tstamp), BW'(6));
        chk("t4_still_halted", BW'(halted), BW'(1));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t4_read_halted", BW'(rd_valid), BW'(0));
        stop_on_err = 1'b0;

        // Re-arm from HALTED; arm+clear while ARMED goes IDLE and keeps data
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t5_rearm_busy", BW'(busy), BW'(1));
        chk("t5_rearm_halt", BW'(halted), BW'(0));
        result_flag = 1'b1; result = BW'(32'h31);
        tick();
        result = BW'(32'h32);
        tick();
        result_flag = 1'b0;
        arm = 1'b1; clear = 1'b1;
        tick();
        arm = 1'b0; clear = 1'b0;
        chk("t5_idle_busy", BW'(busy), BW'(0));
        chk("t5_idle_halt", BW'(halted), BW'(0));
        chk("t5_keep_valid", BW'(rd_valid), BW'(1));
        chk("t5_keep_d", rd_data, BW'(32'h31));
        chk("t5_keep_err", BW'(err_count), BW'(2));
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t5_flush", BW'(rd_valid), BW'(0));
        chk("t5_err0", BW'(err_count), BW'(0));
        chk("t5_busy", BW'(busy), BW'(1));

        // Reset mid-session with two entries queued, alongside arm/pop/flag
        result_flag = 1'b1; result = BW'(32'h61);
        tick();
        result = BW'(32'h62);
        tick();
        result_flag = 1'b0;
        chk("t6_pre_valid", BW'(rd_valid), BW'(1));
        chk("t6_pre_err", BW'(err_count), BW'(2));
        resetb = 1'b0; arm = 1'b1; rd_ready = 1'b1; result_flag = 1'b1;
        tick();
        resetb = 1'b1; arm = 1'b0; rd_ready = 1'b0; result_flag = 1'b0;
        chk("t6_valid", BW'(rd_valid), BW'(0));
        chk("t6_busy", BW'(busy), BW'(0));
        chk("t6_halted", BW'(halted), BW'(0));
        chk("t6_err", BW'(err_count), BW'(0));
        chk("t6_ovf", BW'(overflow), BW'(0));
        chk("t6_data", rd_data, BW'(0));
        chk("t6_ts", BW'(rd_tstamp), BW'(0));
        chk("t6_state", BW'(dut.state), BW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddls_err_capture.md
DDLS_ERR_CAPTURE -- requirements
Module: ddls_err_capture

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- BUFFERWIDTH, 256, width of a compare-stage result word.
- DEPTH, 4, capture FIFO entries (power of two).
- CNTW, 16, width of the timestamp and error counter.
REQ-002 Clock and reset SHALL be clk and resetb: resetb is synchronous, active-low; clk is the clock.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, clock.
- resetb, in, 1, synchronous active-low reset.
- arm, in, 1, start a capture session.
- clear, in, 1, abort the session and return to idle.
- stop_on_err, in, 1, halt capture after the first mismatch.
- result_flag, in, 1, mismatch flag from the compare stage.
- result, in, BUFFERWIDTH, mismatch word from the compare stage.
- rd_valid, out, 1, the FIFO head entry is valid.
- rd_ready, in, 1, the consumer accepts the head entry.
- rd_data, out, BUFFERWIDTH, the head entry's result word.
- rd_tstamp, out, CNTW, the head entry's timestamp.
- err_count, out, CNTW, mismatches seen in this session.
- overflow, out, 1, sticky: a mismatch was dropped because the FIFO was full.
- busy, out, 1, the block is in state ARMED.
- halted, out, 1, the block is in state HALTED.

Function
REQ-004 The FSM SHALL have the states IDLE, ARMED and HALTED; the state after reset SHALL be IDLE.
REQ-005 clear SHALL move the FSM to IDLE from any state and SHALL take priority over arm in the same cycle.
REQ-006 arm, in IDLE or HALTED, SHALL do all of the following in the same edge, then enter ARMED:
- flush the FIFO;
- zero the timestamp and err_count;
- clear overflow.
REQ-007 arm in ARMED SHALL have no effect.
REQ-008 In ARMED, if result_flag=1 and stop_on_err=1, the FSM SHALL enter HALTED at the next edge, after capturing that mismatch.
REQ-009 The timestamp SHALL count as follows:
- it increments by 1 every cycle in ARMED;
- it holds in IDLE and HALTED;
- it wraps from 2^CNTW-1 to 0;
- it reads 0 in the first ARMED cycle.
REQ-010 A capture event SHALL be ARMED with result_flag=1; result_flag and result are sampled in that same cycle with zero input latency.
REQ-011 On a capture event, err_count SHALL increment and SHALL saturate at 2^CNTW-1 without wrapping.
REQ-012 On a capture event with the FIFO not full, the FIFO SHALL push {timestamp of that cycle, result}.
REQ-013 On a capture event with the FIFO full and no pop in the same cycle, the entry SHALL be dropped and overflow set to 1; FIFO contents SHALL be unchanged.
REQ-014 A simultaneous push and pop on a full FIFO SHALL accept the push, and the occupancy SHALL stay at DEPTH.
REQ-015 A simultaneous push and pop on an empty FIFO SHALL leave the FIFO empty.
REQ-016 The FIFO SHALL be first-word-fall-through with these timing rules:
- rd_valid=1 exactly when the FIFO is not empty;
- rd_data and rd_tstamp show the head entry;
- a pushed entry becomes visible on rd_valid at the next edge.
REQ-017 A pop SHALL occur when rd_valid and rd_ready are both 1; rd_ready while rd_valid=0 SHALL be ignored.
REQ-018 rd_data and rd_tstamp SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-019 Readout SHALL work in all states; clear SHALL NOT flush the FIFO, and only arm or reset SHALL flush it.
REQ-020 busy and halted SHALL be registered decodes of the FSM state.

Reset
REQ-021 With resetb=0 at a clk edge, the block SHALL set the FSM to IDLE and empty the FIFO.
REQ-022 Reset SHALL also zero the timestamp and err_count, and clear overflow.
REQ-023 Reset SHALL drive rd_valid, busy and halted to 0, and rd_data and rd_tstamp to all zeros.
REQ-024 Reset SHALL take priority over arm, clear and any capture or pop in the same cycle.

Structure
REQ-025 A shared package ddls_pkg SHALL hold the BUFFERWIDTH default and the FSM state encoding (IDLE=0, ARMED=1, HALTED=2).
REQ-026 The FIFO SHALL be a separate sub-module, ddls_err_fifo, with:
- width CNTW+BUFFERWIDTH and depth DEPTH;
- a flush input;
- push/pop ports plus full and empty outputs.

Verification
REQ-027 Arm, then pulse result_flag in cycles 3 and 7 with result=0x1 and 0x2 -> err_count=2, and entries read out in order as (tstamp 3, 0x1) then (tstamp 7, 0x2).
REQ-028 With rd_ready=0, flag 6 consecutive cycles -> 4 entries stored, overflow=1, err_count=6, and rd_data stable throughout.
REQ-029 With stop_on_err=1, flag in cycle 5 -> halted=1 the next cycle; flags afterwards leave err_count=1 and the timestamp frozen at 6.
REQ-030 Fill the FIFO, then push and pop in the same cycle -> no overflow, occupancy 4, and the new entry at the tail.
REQ-031 Assert arm and clear together while ARMED -> IDLE; FIFO contents retained; a later arm empties the FIFO and sets rd_valid=0.
REQ-032 Drop resetb mid-session with 2 entries queued -> all outputs 0 at the next edge and the state is IDLE.
